batch_feeder: RTL and testbench

//  Host-side end of the accelerator batch streams. Per batch it reads SS+1 words from a source buffer,

---
 rtl/tiny_dnn_pkg.sv | 20 ++
 rtl/stream_skid.sv | 59 +++++
 rtl/batch_feeder.sv | 174 +++++++++++++++++
 tb/tb_batch_feeder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tiny_dnn_pkg
// Brief    : Shared types and count widths for the batch stream feeder.
// Revision : 1.0 - initial release
// ============================================================================
package tiny_dnn_pkg;

    localparam int c_WORD_W  = 12;
    localparam int c_BATCH_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        FIN  = 2'd3
    } feed_state_t;

endpackage : tiny_dnn_pkg
`default_nettype wire

// File: rtl/stream_skid.sv
`default_nettype none
// ============================================================================
// Module   : stream_skid
// Brief    : Two-entry valid/ready buffer with occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
module stream_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign out_valid = (r_count != 2'd0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign in_ready  = (r_count != 2'd2) | out_ready;
    assign occupancy = r_count;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : stream_skid
`default_nettype wire

// File: rtl/batch_feeder.sv
`default_nettype none
// ============================================================================
// Module   : batch_feeder
// Brief    : Streams SS+1 source words out, then stores DS+1 result words,
//            for NB+1 batches.
// Revision : 1.0 - initial release
// ============================================================================
module batch_feeder
    import tiny_dnn_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [c_WORD_W-1:0]  ss,
    input  logic [c_WORD_W-1:0]  ds,
    input  logic [c_BATCH_W-1:0] nb,
    input  logic [AW-1:0]        src_base,
    input  logic [AW-1:0]        dst_base,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_re,
    output logic [AW-1:0]        mem_ra,
    input  logic [DW-1:0]        mem_rd,
    output logic                 res_we,
    output logic [AW-1:0]        res_wa,
    output logic [DW-1:0]        res_wd,
    output logic                 src_valid,
    output logic                 src_last,
    output logic [DW-1:0]        src_data,
    input  logic                 src_ready,
    input  logic                 dst_valid,
    input  logic [DW-1:0]        dst_data,
    output logic                 dst_ready
);

    feed_state_t          r_state;
    feed_state_t          w_next;
    logic [c_WORD_W-1:0]  r_ss;
    logic [c_WORD_W-1:0]  r_ds;
    logic [c_BATCH_W-1:0] r_nb;
    logic [AW-1:0]        r_src_base;
    logic [AW-1:0]        r_dst_base;
    logic [AW-1:0]        r_src_off;
    logic [AW-1:0]        r_dst_off;
    logic [c_WORD_W-1:0]  r_rd_idx;
    logic [c_WORD_W-1:0]  r_wr_idx;
    logic [c_BATCH_W-1:0] r_batch;
    logic                 r_rd_done;
    logic                 r_pend;
    logic                 r_pend_last;

    logic [1:0]           w_occ;
    logic [2:0]           w_fill;
    logic                 w_room;
    logic                 w_issue;
    logic                 w_pop;
    logic                 w_src_fin;
    logic                 w_dst_acc;
    logic                 w_dst_fin;
    logic                 w_skid_in_ready;

    stream_skid #(
        .W(DW + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_pend & w_skid_in_ready),
        .in_data   ({r_pend_last, mem_rd}),
        .in_ready  (w_skid_in_ready),
        .out_valid (src_valid),
        .out_data  ({src_last, src_data}),
        .out_ready (src_ready),
        .occupancy (w_occ)
    );

    // A read may issue only if the word it returns will still find a slot,
    // counting words already in flight and the one leaving this cycle.
    assign w_pop     = src_valid & src_ready;
    assign w_fill    = {1'b0, w_occ} + {2'b00, r_pend};
    assign w_room    = w_pop ? (w_fill <= 3'd2) : (w_fill <= 3'd1);
    assign w_issue   = (r_state == SEND) & ~r_rd_done & w_room;
    assign w_src_fin = (r_state == SEND) & w_pop & src_last;
    assign w_dst_acc = (r_state == RECV) & dst_valid;
    assign w_dst_fin = w_dst_acc & (r_wr_idx == r_ds);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SEND;
            SEND:    if (w_src_fin) w_next = RECV;
            RECV:    if (w_dst_fin) w_next = (r_batch == r_nb) ? FIN : SEND;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        done      = (r_state == FIN);
        dst_ready = (r_state == RECV);
        mem_re    = w_issue;
        mem_ra    = w_issue ? (r_src_base + r_src_off) : '0;
        res_we    = w_dst_acc;
        res_wa    = w_dst_acc ? (r_dst_base + r_dst_off) : '0;
        res_wd    = w_dst_acc ? dst_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ss        <= '0;
            r_ds        <= '0;
            r_nb        <= '0;
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_src_off   <= '0;
            r_dst_off   <= '0;
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_batch     <= '0;
            r_rd_done   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pend      <= w_issue;
            r_pend_last <= w_issue & (r_rd_idx == r_ss);

            if ((r_state == IDLE) && start) begin
                r_ss       <= ss;
                r_ds       <= ds;
                r_nb       <= nb;
                r_src_base <= src_base;
                r_dst_base <= dst_base;
                r_src_off  <= '0;
                r_dst_off  <= '0;
                r_rd_idx   <= '0;
                r_wr_idx   <= '0;
                r_batch    <= '0;
                r_rd_done  <= 1'b0;
            end

            if (w_issue) begin
                r_src_off <= r_src_off + AW'(1);
                if (r_rd_idx == r_ss) begin
                    r_rd_idx  <= '0;
                    r_rd_done <= 1'b1;
                end else begin
                    r_rd_idx <= r_rd_idx + 12'd1;
                end
            end

            // Re-arm reads for the next batch once its source phase closes.
            if (w_src_fin) begin
                r_rd_done <= 1'b0;
            end

            if (w_dst_acc) begin
                r_dst_off <= r_dst_off + AW'(1);
                if (w_dst_fin) begin
                    r_wr_idx <= '0;
                    r_batch  <= r_batch + 8'd1;
                end else begin
                    r_wr_idx <= r_wr_idx + 12'd1;
                end
            end
        end
    end

endmodule : batch_feeder
`default_nettype wire

// File: tb/tb_batch_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_batch_feeder
// Brief    : Scoreboard bench for batch_feeder: source words, result writes,
//            back-pressure, address wrap and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_batch_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] ss, ds;
    logic [7:0]  nb;
    logic [15:0] src_base, dst_base;
    logic        busy, done, mem_re, res_we, src_valid, src_last, src_ready;
    logic        dst_valid, dst_ready;
    logic [15:0] mem_ra, res_wa;
    logic [31:0] mem_rd, res_wd, src_data, dst_data;

    batch_feeder #(.DW(32), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ss(ss), .ds(ds), .nb(nb),
        .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
        .mem_re(mem_re), .mem_ra(mem_ra), .mem_rd(mem_rd),
        .res_we(res_we), .res_wa(res_wa), .res_wd(res_wd),
        .src_valid(src_valid), .src_last(src_last), .src_data(src_data),
        .src_ready(src_ready), .dst_valid(dst_valid), .dst_data(dst_data),
        .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [32:0] exp_src[$], obs_src[$];
    logic [15:0] exp_ra[$],  obs_ra[$];
    logic [47:0] exp_res[$], obs_res[$];
    logic [31:0] dst_q[$];

    int   rdy_mode = 0;
    int   cyc = 0, busy_cyc, fv_cyc, first_hs, last_hs;
    int   done_cnt, early_cnt, hold_viol, src_needed;
    bit   dst_hs = 0, prev_stall = 0, timed_out;
    logic [32:0] prev_word;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Source buffer: data one cycle after the read enable.
    always @(posedge clk) mem_rd <= mem_re ? memf(mem_ra) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        #1;
        if (dst_hs && dst_q.size() > 0) void'(dst_q.pop_front());
        dst_hs = 0;
        if (rdy_mode == 0) src_ready = 1'b1;
        else               src_ready = ~src_ready;
        dst_valid = (dst_q.size() > 0);
        dst_data  = (dst_q.size() > 0) ? dst_q[0] : 32'h0;
    end

    always @(negedge clk) begin
        cyc++;
        if (dst_ready && obs_src.size() < src_needed) early_cnt++;
        if (prev_stall && (src_valid !== 1'b1 || {src_last, src_data} !== prev_word)) hold_viol++;
        prev_stall = src_valid && !src_ready;
        prev_word  = {src_last, src_data};
        if (busy && busy_cyc < 0) busy_cyc = cyc;
        if (src_valid && fv_cyc < 0) fv_cyc = cyc;
        if (src_valid && src_ready) begin
            obs_src.push_back({src_last, src_data});
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        if (mem_re) obs_ra.push_back(mem_ra);
        if (res_we) obs_res.push_back({res_wa, res_wd});
        if (done) done_cnt++;
        dst_hs = dst_valid && dst_ready;
    end

    // Builds the expected queues, preloads the result stream, pulses start.
    task automatic run_job(input logic [11:0] s, input logic [11:0] d, input logic [7:0] n,
                           input logic [15:0] sb, input logic [15:0] db, input int mode,
                           input bit wait_done);
        logic [15:0] a;
        logic [31:0] w;
        int so = 0, dof = 0;
        @(negedge clk);
        rdy_mode = mode;
        exp_src.delete(); obs_src.delete(); exp_ra.delete(); obs_ra.delete();
        exp_res.delete(); obs_res.delete(); dst_q.delete();
        busy_cyc = -1; fv_cyc = -1; first_hs = -1; last_hs = -1;
        done_cnt = 0; early_cnt = 0; hold_viol = 0; prev_stall = 0; dst_hs = 0;
        src_needed = int'(s) + 1;
        for (int b = 0; b <= int'(n); b++) begin
            for (int i = 0; i <= int'(s); i++) begin
                a = sb + 16'(so); so++;
                exp_ra.push_back(a);
                exp_src.push_back({(i == int'(s)), memf(a)});
            end
            for (int i = 0; i <= int'(d); i++) begin
                a = db + 16'(dof); dof++;
                w = {8'hD5, 8'(b), 4'h0, 12'(i)};
                dst_q.push_back(w);
                exp_res.push_back({a, w});
            end
        end
        ss = s; ds = d; nb = n; src_base = sb; dst_base = db;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 0;
        if (wait_done) begin
            for (int k = 0; k < 2000 && done_cnt == 0; k++) @(negedge clk);
            timed_out = (done_cnt == 0);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; ss = 0; ds = 0; nb = 0; src_base = 0; dst_base = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mem_re, res_we, src_valid, src_last, dst_ready} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done, mem_re, res_we, src_valid, src_last, dst_ready});
        end
        checks++;
        if ({mem_ra, res_wa, res_wd, src_data} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", {mem_ra, res_wa, res_wd, src_data});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_re !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b mem_re=%b want 0 0", busy, mem_re);
        end
    endtask

    task automatic test_basic;
        run_job(12'd3, 12'd1, 8'd0, 16'h0040, 16'h0800, 0, 1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout: done not seen within budget"); end
        checks++;
        if (obs_src.size() != exp_src.size()) begin
            failures++; $display("FAIL basic_src_count: got %0d want %0d", obs_src.size(), exp_src.size());
        end
        for (int i = 0; i < exp_src.size() && i < obs_src.size(); i++) begin
            checks++;
            if (obs_src[i] !== exp_src[i]) begin
                failures++; $display("FAIL basic_src[%0d]: got %h want %h", i, obs_src[i], exp_src[i]);
            end
        end
        checks++;
        if (obs_res.size() != exp_res.size()) begin
            failures++; $display("FAIL basic_res_count: got %0d want %0d", obs_res.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                failures++; $display("FAIL basic_res[%0d]: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        checks++;
        if (fv_cyc - busy_cyc != 2) begin
            failures++; $display("FAIL basic_latency: got %0d cycles want 2", fv_cyc - busy_cyc);
        end
        checks++;
        if (last_hs - first_hs != 3) begin
            failures++; $display("FAIL basic_throughput: got %0d cycles want 3", last_hs - first_hs);
        end
        checks++;
        if (obs_ra.size() != 4) begin failures++; $display("FAIL basic_reads: got %0d want 4", obs_ra.size()); end
    endtask

    task automatic test_backpressure;
        run_job(12'd7, 12'd0, 8'd0, 16'h1000, 16'h2000, 1, 1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL bp_timeout: done not seen within budget"); end
        checks++;
        if (obs_src.size() != exp_src.size()) begin
            failures++; $display("FAIL bp_src_count: got %0d want %0d", obs_src.size(), exp_src.size());
        end
        for (int i = 0; i < exp_src.size() && i < obs_src.size(); i++) begin
            checks++;
            if (obs_src[i] !== exp_src[i]) begin
                failures++; $display("FAIL bp_src[%0d]: got %h want %h", i, obs_src[i], exp_src[i]);
            end
        end
        checks++;
        if (hold_viol != 0) begin failures++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
        checks++;
        if (obs_ra.size() != 8) begin failures++; $display("FAIL bp_reads: got %0d want 8", obs_ra.size()); end
    endtask

    task automatic test_multi_batch;
        run_job(12'd0, 12'd0, 8'd2, 16'h0300, 16'h0500, 0, 1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL multi_timeout: done not seen within budget"); end
        checks++;
        if (obs_src.size() != 3) begin failures++; $display("FAIL multi_src_count: got %0d want 3", obs_src.size()); end
        for (int i = 0; i < exp_src.size() && i < obs_src.size(); i++) begin
            checks++;
            if (obs_src[i] !== exp_src[i]) begin
                failures++; $display("FAIL multi_src[%0d]: got %h want %h", i, obs_src[i], exp_src[i]);
            end
        end
        checks++;
        if (obs_res.size() != 3) begin failures++; $display("FAIL multi_res_count: got %0d want 3", obs_res.size()); end
        for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                failures++; $display("FAIL multi_res[%0d]: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL multi_done: got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_dst_early;
        run_job(12'd5, 12'd2, 8'd0, 16'h0A00, 16'h0B00, 1, 1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL early_timeout: done not seen within budget"); end
        checks++;
        if (early_cnt != 0) begin failures++; $display("FAIL early_ready: got %0d cycles want 0", early_cnt); end
        checks++;
        if (obs_res.size() != exp_res.size()) begin
            failures++; $display("FAIL early_res_count: got %0d want %0d", obs_res.size(), exp_res.size());
        end
        for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                failures++; $display("FAIL early_res[%0d]: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_wrap;
        run_job(12'd3, 12'd1, 8'd0, 16'hFFFE, 16'hFFFF, 0, 1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL wrap_timeout: done not seen within budget"); end
        checks++;
        if (obs_ra.size() != exp_ra.size()) begin
            failures++; $display("FAIL wrap_ra_count: got %0d want %0d", obs_ra.size(), exp_ra.size());
        end
        for (int i = 0; i < exp_ra.size() && i < obs_ra.size(); i++) begin
            checks++;
            if (obs_ra[i] !== exp_ra[i]) begin
                failures++; $display("FAIL wrap_ra[%0d]: got %h want %h", i, obs_ra[i], exp_ra[i]);
            end
        end
        for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                failures++; $display("FAIL wrap_res[%0d]: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        run_job(12'd7, 12'd1, 8'd0, 16'h0100, 16'h0200, 0, 0);
        for (int k = 0; k < 100 && obs_src.size() < 2; k++) @(negedge clk);
        checks++;
        if (obs_src.size() < 2) begin
            failures++; $display("FAIL arst_progress: got %0d words want 2", obs_src.size());
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_re, res_we, src_valid, dst_ready} !== 6'b0) begin
            failures++;
            $display("FAIL arst_outputs: got %b want 000000", {busy, done, mem_re, res_we, src_valid, dst_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (done_cnt != 0) begin failures++; $display("FAIL arst_no_done: got %0d pulses want 0", done_cnt); end
        run_job(12'd3, 12'd1, 8'd0, 16'h0100, 16'h0200, 0, 1);
        checks++;
        if (timed_out) begin failures++; $display("FAIL arst_rerun_timeout: done not seen within budget"); end
        checks++;
        if (obs_src.size() != exp_src.size()) begin
            failures++; $display("FAIL arst_src_count: got %0d want %0d", obs_src.size(), exp_src.size());
        end
        for (int i = 0; i < exp_src.size() && i < obs_src.size(); i++) begin
            checks++;
            if (obs_src[i] !== exp_src[i]) begin
                failures++; $display("FAIL arst_src[%0d]: got %h want %h", i, obs_src[i], exp_src[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL arst_done: got %0d pulses want 1", done_cnt); end
    endtask

    initial begin
        src_ready = 1'b1; dst_valid = 1'b0; dst_data = 32'h0; src_needed = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_multi_batch();
        test_dst_early();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_batch_feeder
`default_nettype wire
